// File: rtl/sqrt_result_pack_if.sv
// Output stream of the sqrt result packer.
// The producer drives valid/data, and the consumer drives ready.
interface sqrt_result_pack_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/sqrt_result_pack.sv
// Packs final sqrt iteration results into binary16.
// Results are buffered in a small valid/ready output FIFO.
module sqrt_result_pack #(
    parameter int DEPTH  = 2,
    parameter int EXP_W  = 7,
    parameter int MANT_W = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   it_valid,
    input  logic                   result,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MANT_W-1:0]      mant_in,
    input  logic                   is_nan_in,
    input  logic                   is_pinf_in,
    input  logic                   is_ninf_in,
    sqrt_result_pack_if.master     out_if,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic signed [EXP_W:0] E_ZERO =
        (EXP_W+1)'(-15);
    localparam logic signed [EXP_W:0] E_MAX =
        (EXP_W+1)'(15);

    logic [15:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [15:0]  data_q;
    logic [15:0]  packed_w;
    logic [15:0]  head_next;
    logic [CW-1:0] count_next;
    logic [CW-1:0] cnt_after_pop;

    logic signed [EXP_W:0] exp_ext;
    logic signed [EXP_W:0] biased;

    logic push;
    logic pop;
    logic accept;
    logic drop;
    logic unused_bits;

    assign exp_ext = {exp_in[EXP_W-1], exp_in};
    assign biased  = exp_ext + E_MAX;

    assign unused_bits = ^{biased[EXP_W:5],
                           mant_in[MANT_W-1:10]};

    always_comb begin
        packed_w = {sign_in, biased[4:0], mant_in[9:0]};
        if (is_nan_in | is_ninf_in)
            packed_w = {sign_in, 5'h1F, 10'h200};
        else if (is_pinf_in)
            packed_w = 16'h7C00;
        else if (exp_ext == E_ZERO)
            packed_w = {sign_in, 15'h0000};
        else if (exp_ext > E_MAX)
            packed_w = {sign_in, 5'h1F, 10'h000};
        else if (exp_ext < E_ZERO)
            packed_w = {sign_in, 15'h0000};
    end

    assign full             = (count == CW'(DEPTH));
    assign out_if.out_valid = (count != '0);
    assign out_if.out_data  = data_q;

    assign push   = it_valid & result;
    assign pop    = out_if.out_valid & out_if.out_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_comb begin
        count_next = count;
        unique case ({accept, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // The head register must show the entry that will sit at
    // the read pointer next cycle, which may be this push.
    assign rd_next       = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign cnt_after_pop = count - CW'(pop);

    always_comb begin
        head_next = mem[rd_next];
        if (cnt_after_pop == '0)
            head_next = packed_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            data_q   <= 16'h0000;
            drop_err <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= packed_w;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            // An empty FIFO keeps showing the last popped word.
            if (count_next != '0)
                data_q <= head_next;
            if (drop)
                drop_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sqrt_result_pack.sv
// Randomised and directed bench for sqrt_result_pack.
// The reference is a queue-based model with a direct pack function.
module tb_sqrt_result_pack;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        it_valid;
    logic        result;
    logic        sign_in;
    logic [6:0]  exp_in;
    logic [10:0] mant_in;
    logic        is_nan_in;
    logic        is_pinf_in;
    logic        is_ninf_in;
    logic        full;
    logic [1:0]  count;
    logic        drop_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q[$];
    logic [15:0] m_last;
    logic        m_drop;

    sqrt_result_pack_if bus ();

    sqrt_result_pack #(
        .DEPTH (DEPTH),
        .EXP_W (7),
        .MANT_W(11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .it_valid  (it_valid),
        .result    (result),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .is_nan_in (is_nan_in),
        .is_pinf_in(is_pinf_in),
        .is_ninf_in(is_ninf_in),
        .out_if    (bus.master),
        .full      (full),
        .count     (count),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_pack(
        input logic        s,
        input int          e,
        input logic [10:0] m,
        input logic        nan,
        input logic        pinf,
        input logic        ninf
    );
        logic [4:0] be;
        if (nan || ninf) return {s, 5'h1F, 10'h200};
        if (pinf)        return 16'h7C00;
        if (e == -15)    return {s, 15'h0000};
        if (e > 15)      return {s, 5'h1F, 10'h000};
        if (e < -15)     return {s, 15'h0000};
        be = 5'(e + 15);
        return {s, be, m[9:0]};
    endfunction

    function automatic logic [15:0] m_data();
        return (q.size() > 0) ? q[0] : m_last;
    endfunction

    task automatic idle();
        it_valid   = 1'b0;
        result     = 1'b0;
        sign_in    = 1'b0;
        exp_in     = 7'd0;
        mant_in    = 11'd0;
        is_nan_in  = 1'b0;
        is_pinf_in = 1'b0;
        is_ninf_in = 1'b0;
    endtask

    // Advance the model with the current inputs, then one clock.
    task automatic cycle();
        logic [15:0] w;
        bit pop;
        if (rst) begin
            q.delete();
            m_last = 16'h0000;
            m_drop = 1'b0;
        end else begin
            w = ref_pack(sign_in, int'($signed(exp_in)),
                         mant_in, is_nan_in, is_pinf_in,
                         is_ninf_in);
            pop = (q.size() > 0) && bus.out_ready;
            if (pop) m_last = q.pop_front();
            if (it_valid && result) begin
                if (q.size() < DEPTH) q.push_back(w);
                else m_drop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic s, input int e,
                           input logic [10:0] m);
        it_valid = 1'b1;
        result   = 1'b1;
        sign_in  = s;
        exp_in   = 7'(e);
        mant_in  = m;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        do_reset();
        n_cmp++;
        if (count !== 2'd0 || bus.out_valid !== 1'b0 ||
            full !== 1'b0 || drop_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state cnt=%0d v=%b f=%b d=%b",
                     count, bus.out_valid, full, drop_err);
        end
        n_cmp++;
        if (bus.out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_data got=%h exp=0000",
                     bus.out_data);
        end
    endtask

    task automatic test_normal();
        bus.out_ready = 1'b1;
        set_res(1'b0, 1, 11'h400);
        cycle();
        idle();
        n_cmp++;
        if (bus.out_valid !== 1'b1 ||
            bus.out_data !== 16'h4000) begin
            n_err++;
            $display("FAIL normal v=%b got=%h exp=4000",
                     bus.out_valid, bus.out_data);
        end
        cycle();
        n_cmp++;
        if (count !== 2'd0) begin
            n_err++;
            $display("FAIL normal_drain cnt=%0d exp=0", count);
        end
    endtask

    task automatic test_specials();
        logic [15:0] exp_w [4] =
            '{16'h8000, 16'hFE00, 16'h7C00, 16'hFE00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_res(1'b1, 3, 11'h4AB);
            if (i == 0) begin
                exp_in = 7'(-15);
            end
            if (i == 1) is_nan_in = 1'b1;
            if (i == 2) is_pinf_in = 1'b1;
            if (i == 3) is_ninf_in = 1'b1;
            cycle();
            idle();
            n_cmp++;
            if (bus.out_valid !== 1'b1 ||
                bus.out_data !== exp_w[i]) begin
                n_err++;
                $display("FAIL special%0d got=%h exp=%h",
                         i, bus.out_data, exp_w[i]);
            end
            cycle();
        end
    endtask

    task automatic test_filter();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            it_valid = 1'b1;
            result   = 1'b0;
            exp_in   = 7'($urandom_range(0, 127));
            mant_in  = 11'($urandom);
            cycle();
        end
        n_cmp++;
        if (count !== 2'd0) begin
            n_err++;
            $display("FAIL filter_idle cnt=%0d exp=0", count);
        end
        set_res(1'b0, -1, 11'h5A8);
        cycle();
        idle();
        n_cmp++;
        if (count !== 2'd1 || bus.out_data !== 16'h39A8) begin
            n_err++;
            $display("FAIL filter cnt=%0d got=%h exp=1/39a8",
                     count, bus.out_data);
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_res(1'b0, i, 11'h400);
            cycle();
            idle();
            if (i == 2) begin
                n_cmp++;
                if (count !== 2'd2 || full !== 1'b1 ||
                    drop_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_full cnt=%0d f=%b d=%b",
                             count, full, drop_err);
                end
            end
        end
        n_cmp++;
        if (drop_err !== 1'b1 || count !== 2'd2) begin
            n_err++;
            $display("FAIL bp_drop d=%b cnt=%0d exp=1/2",
                     drop_err, count);
        end
        bus.out_ready = 1'b1;
        n_cmp++;
        if (bus.out_data !== 16'h4000) begin
            n_err++;
            $display("FAIL bp_head0 got=%h exp=4000",
                     bus.out_data);
        end
        cycle();
        n_cmp++;
        if (bus.out_data !== 16'h4400) begin
            n_err++;
            $display("FAIL bp_head1 got=%h exp=4400",
                     bus.out_data);
        end
        cycle();
        n_cmp++;
        if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty cnt=%0d exp=0", count);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        bus.out_ready = 1'b0;
        set_res(1'b0, 1, 11'h400);
        cycle();
        set_res(1'b0, 2, 11'h400);
        cycle();
        bus.out_ready = 1'b1;
        set_res(1'b0, 3, 11'h400);
        cycle();
        idle();
        n_cmp++;
        if (count !== 2'd2 || drop_err !== 1'b0 ||
            bus.out_data !== 16'h4400) begin
            n_err++;
            $display("FAIL fullpop cnt=%0d d=%b got=%h",
                     count, drop_err, bus.out_data);
        end
        cycle();
        n_cmp++;
        if (count !== 2'd1 || bus.out_data !== 16'h4800) begin
            n_err++;
            $display("FAIL fullpop3 cnt=%0d got=%h exp=4800",
                     count, bus.out_data);
        end
        cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_res(1'b0, 4, 11'h7FF);
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if (count !== 2'd0 || bus.out_valid !== 1'b0 ||
            full !== 1'b0 || drop_err !== 1'b0 ||
            bus.out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_mid cnt=%0d v=%b f=%b d=%b o=%h",
                     count, bus.out_valid, full, drop_err,
                     bus.out_data);
        end
        set_res(1'b1, 0, 11'h6C0);
        cycle();
        idle();
        n_cmp++;
        if (bus.out_valid !== 1'b1 ||
            bus.out_data !== 16'hBEC0) begin
            n_err++;
            $display("FAIL rst_mid_push v=%b got=%h exp=bec0",
                     bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        logic [15:0] exp_d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            idle();
            rst           = ($urandom_range(0, 99) == 0);
            it_valid      = ($urandom_range(0, 3) != 0);
            result        = ($urandom_range(0, 2) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            sign_in       = 1'($urandom);
            mant_in       = 11'($urandom);
            if ($urandom_range(0, 4) == 0)
                exp_in = 7'($urandom_range(0, 127));
            else
                exp_in = 7'($urandom_range(0, 40) - 20);
            is_nan_in  = ($urandom_range(0, 15) == 0);
            is_pinf_in = ($urandom_range(0, 15) == 0);
            is_ninf_in = ($urandom_range(0, 15) == 0);
            cycle();
            exp_d = m_data();
            n_cmp++;
            if (int'(count) !== q.size() ||
                bus.out_valid !== (q.size() != 0) ||
                full !== (q.size() == DEPTH) ||
                drop_err !== m_drop ||
                bus.out_data !== exp_d) begin
                n_err++;
                $display("FAIL rand%0d cnt=%0d/%0d d=%b/%b o=%h/%h",
                         i, count, q.size(), drop_err, m_drop,
                         bus.out_data, exp_d);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        m_last        = 16'h0000;
        m_drop        = 1'b0;
        idle();
        test_reset();
        test_normal();
        test_specials();
        test_filter();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sqrt_result_pack.md
Name: sqrt_result_pack

Overview:
- Downstream neighbour of the sqrt iteration stage in the FP16 square-root datapath.
- Captures the final iteration result, marked by a `result` pulse, along with its sign/exp/mant and special flags.
- Packs the result into an IEEE-754 binary16 word and buffers it in a small FIFO with a valid/ready output handshake.
- Raises `full` so the controller can hold `enable`/`n_valid` of the upstream stage.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2).
- EXP_W, 7, width of signed unbiased exponent from the iteration stage.
- MANT_W, 11, width of mantissa from the iteration stage (bit MANT_W-1 is the hidden bit).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- it_valid  input  1  iteration stage output valid.
- result  input  1  final-result strobe from iteration stage (one cycle).
- sign_in  input  1  result sign.
- exp_in  input  EXP_W  signed unbiased exponent (−15 = zero code, 16 = special code).
- mant_in  input  MANT_W  result mantissa, hidden bit at MSB.
- is_nan_in  input  1  NaN result flag.
- is_pinf_in  input  1  +inf result flag.
- is_ninf_in  input  1  −inf input flag (packs as NaN).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  16  packed binary16 at FIFO head.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- drop_err  output  1  sticky: a result was discarded because FIFO was full.

Behaviour:
- Reset: rst sampled high at a rising edge gives:
  - count=0, out_valid=0, out_data=16'h0000, full=0, drop_err=0;
  - read/write pointers=0.
  - rst mid-operation discards all buffered entries and any push/pop in that cycle.
- Push condition: `push = it_valid & result`. `it_valid` without `result` (intermediate mantissa) is ignored.
- Pop condition: `pop = out_valid & out_ready`.
- Packing is combinational on inputs in the push cycle, with priority top-down:
  1. is_nan_in | is_ninf_in → {sign_in, 5'h1F, 10'h200}.
  2. is_pinf_in → 16'h7C00.
  3. exp_in == −15 → {sign_in, 15'h0000} (signed zero).
  4. exp_in > 15 → {sign_in, 5'h1F, 10'h000}.
  5. exp_in < −15 → {sign_in, 15'h0000}.
  6. Otherwise → {sign_in, (exp_in+15)[4:0], mant_in[9:0]}.
- Bias arithmetic: sign-extend exp_in to EXP_W+1 before adding 15, so no wrap occurs.
- FIFO timing:
  - Write at posedge when the push is accepted.
  - out_data/out_valid reflect the head from the next cycle, so latency from the result pulse to out_valid is 1 cycle when empty.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - When empty, out_data shows the last popped value (0 after reset); consumers must ignore it.
- Accept rule: push is accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle (simultaneous push/pop at full is lossless; count unchanged).
- Drop: push with count==DEPTH and no pop:
  - the entry is discarded and count is unchanged;
  - drop_err←1, held until rst.
- Push and pop on empty: the push is accepted and the pop is ignored (out_valid was 0), so count becomes 1.
- count updates as +1 for push only, −1 for pop only, and 0 for both or neither.
- full = (count==DEPTH). out_valid = (count!=0). Both are registered-state derived, with no combinational path from inputs.
- Pointers wrap modulo DEPTH.

Test Plan:
- Normal result: exp_in=1, mant_in=11'h400, sign_in=0, result pulse, out_ready=1 → next cycle out_valid=1, out_data=16'h4000; count returns to 0 after the pop.
- Specials: exp_in=−15, sign_in=1 → 16'h8000. is_nan_in=1, sign_in=1 → 16'hFE00. is_pinf_in=1 → 16'h7C00. is_ninf_in=1, sign_in=1 → 16'hFE00.
- Intermediate filtering: it_valid=1 with result=0 for 11 cycles, then one result cycle with exp_in=−1, mant_in=11'h5A8 → exactly one entry, 16'h39A8.
- Backpressure: out_ready=0, three result pulses (2.0, 4.0, 8.0 encodings) →
  - count=2 and full=1 after two pulses;
  - the third is dropped and drop_err=1;
  - with out_ready=1, the outputs drain in order as 16'h4000 then 16'h4400 and count reaches 0.
- Full with simultaneous pop: count=2, out_ready=1, result pulse → count stays 2, drop_err stays 0, and the new entry emerges third.
- Reset mid-operation: count=2, drop_err=1, assert rst one cycle → count=0, out_valid=0, full=0, drop_err=0, out_data=0; the next push appears 1 cycle later.
